// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Brief    : Shared types and constants for the instruction-fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

  // One queued fetch result: the byte address and the word the ROM returned
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch addresses are always word aligned; the low two bits are dropped
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_fifo
// Brief    : DEPTH-entry FIFO of fetch entries with push/pop/flush and an
//            occupancy count. The head reads as zero whenever it is empty.
// Revision : 1.0 - initial release
// ============================================================================
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers and occupancy; flush wins over any simultaneous push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({push, pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an empty queue never exposes its contents
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  // Head presentation, forced to zero when nothing is queued
  always_comb begin
    valid = (r_count != '0);
    full  = (r_count == C_CNT_MAX);
    count = r_count;
    rdata = '0;
    if (valid) rdata = r_mem[r_rd_ptr];
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Instruction-fetch stage. Owns the fetch PC, drives the
//            combinational ROM, queues {pc, instr} pairs for decode and
//            flushes/restarts on a branch redirect.
//            Optional macro IF_FETCH_BYPASS_EN: when the queue is empty the
//            ROM word is presented to decode in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  logic [31:0]  r_fetch_pc;
  fetch_entry_t w_head;
  fetch_entry_t w_wdata;
  logic         w_fifo_valid;
  logic         w_fifo_full;
  logic         w_pop;
  logic         w_push;
  logic         w_bypass_take;
  logic         w_advance;

  // Push/pop control: redirect suppresses the push, a pop frees a full slot
  always_comb begin
    w_pop         = w_fifo_valid && out_ready;
`ifdef IF_FETCH_BYPASS_EN
    w_bypass_take = !w_fifo_valid && !redirect_valid && out_ready;
`else
    w_bypass_take = 1'b0;
`endif
    w_push        = !redirect_valid && (!w_fifo_full || w_pop) && !w_bypass_take;
    w_advance     = w_push || w_bypass_take;
    w_wdata.pc    = r_fetch_pc;
    w_wdata.instr = rom_data;
  end

  // Fetch PC: redirect has priority, otherwise step by one word per fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= align_pc(redirect_pc);
    end else if (w_advance) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .rdata (w_head),
    .valid (w_fifo_valid),
    .full  (w_fifo_full),
    .count (q_count)
  );

  // Decode-facing outputs: queue head, or the live ROM word when bypassing
  always_comb begin
    rom_addr  = r_fetch_pc;
    out_valid = w_fifo_valid;
    out_pc    = w_head.pc;
    out_instr = w_head.instr;
`ifdef IF_FETCH_BYPASS_EN
    if (!w_fifo_valid && !redirect_valid) begin
      out_valid = 1'b1;
      out_pc    = r_fetch_pc;
      out_instr = rom_data;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Self-checking bench for if_fetch_queue: directed vector table,
//            hand-written reset/bypass sequences and a randomized run against
//            a queue-based reference model. Honours IF_FETCH_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [CW-1:0] q_count;
  logic [31:0]   salt = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural ROM: word is a scrambled copy of its address
  function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic [31:0] s);
    return {a[15:0] ^ 16'hBEEF, ~a[31:16]} ^ s;
  endfunction

  assign rom_data = rom_fn(rom_addr, salt);

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .q_count        (q_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries plus the next fetch address
  fetch_entry_t mq[$];
  logic [31:0]  mpc;

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
  endtask

  task automatic model_check(input string tag);
    logic        ev;
    logic [31:0] epc, ei;
    ev = 1'b0; epc = '0; ei = '0;
    if (mq.size() > 0) begin
      ev = 1'b1; epc = mq[0].pc; ei = mq[0].instr;
    end
`ifdef IF_FETCH_BYPASS_EN
    else if (!redirect_valid) begin
      ev = 1'b1; epc = mpc; ei = rom_fn(mpc, salt);
    end
`endif
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".out_pc"},    out_pc,          epc);
    check({tag, ".out_instr"}, out_instr,       ei);
    check({tag, ".q_count"},   32'(q_count),    32'(mq.size()));
    check({tag, ".rom_addr"},  rom_addr,        mpc);
  endtask

  // Advance the model by one clock according to the current inputs
  task automatic model_step();
    fetch_entry_t e;
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      bit bypassed = 1'b0;
      if (mq.size() > 0) begin
        if (out_ready) void'(mq.pop_front());
      end else begin
`ifdef IF_FETCH_BYPASS_EN
        if (out_ready) bypassed = 1'b1;
`endif
      end
      if (bypassed) begin
        mpc = mpc + 32'd4;
      end else if (mq.size() < DEPTH) begin
        e.pc = mpc; e.instr = rom_fn(mpc, salt);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  // Inputs are already applied; check, clock, land 1ns after the edge
  task automatic cycle_model(input string tag);
    #1;
    model_check(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0; salt = '0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_pc",    out_pc,         32'd0);
    check("rst.out_instr", out_instr,      32'd0);
    check("rst.q_count",   32'(q_count),   32'd0);
    check("rst.rom_addr",  rom_addr,       RPC);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vec [19];

  initial begin
    // Fill, hold while full, simultaneous push/pop, redirect, PC wrap
    vec[0]  = '{0, 32'h0, 0, 0, 32'h0,        0, 32'h0};
    vec[1]  = '{0, 32'h0, 0, 1, 32'h0,        1, 32'h4};
    vec[2]  = '{0, 32'h0, 0, 1, 32'h0,        2, 32'h8};
    vec[3]  = '{0, 32'h0, 0, 1, 32'h0,        3, 32'hC};
    vec[4]  = '{0, 32'h0, 0, 1, 32'h0,        4, 32'h10};
    vec[5]  = '{0, 32'h0, 0, 1, 32'h0,        4, 32'h10};
    vec[6]  = '{0, 32'h0, 1, 1, 32'h0,        4, 32'h10};
    vec[7]  = '{0, 32'h0, 0, 1, 32'h4,        4, 32'h14};
    vec[8]  = '{0, 32'h0, 1, 1, 32'h4,        4, 32'h14};
    vec[9]  = '{0, 32'h0, 1, 1, 32'h8,        4, 32'h18};
    vec[10] = '{1, 32'h22, 0, 1, 32'hC,       4, 32'h1C};
    vec[11] = '{0, 32'h0, 0, 0, 32'h0,        0, 32'h20};
    vec[12] = '{0, 32'h0, 1, 1, 32'h20,       1, 32'h24};
    vec[13] = '{0, 32'h0, 1, 1, 32'h24,       1, 32'h28};
    vec[14] = '{1, 32'hFFFF_FFFF, 1, 1, 32'h28, 1, 32'h2C};
    vec[15] = '{0, 32'h0, 0, 0, 32'h0,        0, 32'hFFFF_FFFC};
    vec[16] = '{0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0};
    vec[17] = '{0, 32'h0, 1, 1, 32'hFFFF_FFFC, 2, 32'h4};
    vec[18] = '{0, 32'h0, 1, 1, 32'h0,        2, 32'h8};

    do_reset();

`ifndef IF_FETCH_BYPASS_EN
    for (int i = 0; i < 19; i++) begin
      redirect_valid = vec[i].redir;
      redirect_pc    = vec[i].rpc;
      out_ready      = vec[i].rdy;
      #1;
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vec[i].ev));
      check($sformatf("vec%0d.out_pc", i),    out_pc,          vec[i].epc);
      check($sformatf("vec%0d.out_instr", i), out_instr,
            vec[i].ev ? rom_fn(vec[i].epc, 32'h0) : 32'h0);
      check($sformatf("vec%0d.q_count", i),   32'(q_count),    vec[i].ecnt);
      check($sformatf("vec%0d.rom_addr", i),  rom_addr,        vec[i].eaddr);
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
    out_ready = 1'b0;
`else
    // Empty queue with decode ready: the ROM word goes straight out
    out_ready = 1'b1;
    #1;
    check("byp.out_valid", 32'(out_valid), 32'd1);
    check("byp.out_pc",    out_pc,         RPC);
    check("byp.out_instr", out_instr,      rom_fn(RPC, salt));
    check("byp.q_count",   32'(q_count),   32'd0);
    @(posedge clk);
    #1;
    check("byp.rom_addr",  rom_addr,       RPC + 32'd4);
    check("byp.q_count2",  32'(q_count),   32'd0);
    out_ready = 1'b0;
`endif

    // Asynchronous reset in the middle of a stream with two entries queued
    do_reset();
    out_ready = 1'b0;
    cycle_model("pre");
    cycle_model("pre");
    check("mid.q_count_before", 32'(q_count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.q_count",   32'(q_count),   32'd0);
    check("mid.rom_addr",  rom_addr,       RPC);
    check("mid.out_pc",    out_pc,         32'd0);
    @(posedge clk);
    #1;
    check("mid.hold_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    model_reset();

    // Randomized traffic with alternating drain/fill phases
    for (int i = 0; i < 600; i++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : $urandom;
      if (((i / 40) % 2) == 0) out_ready = ($urandom_range(0, 3) != 0);
      else                     out_ready = ($urandom_range(0, 3) == 0);
      salt = $urandom;
      cycle_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction ROM and downstream of nothing but reset/redirect.
- Owns the fetch PC and drives the ROM address; the ROM answers combinationally in the same cycle.
- Captures {pc, instr} pairs into a small FIFO and presents them to decode with a valid/ready handshake.
- A branch/jump redirect flushes all queued entries and restarts fetch at the new PC.

Parameters:
- DEPTH, 4: queue entries; power of 2, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_addr  out  32  byte address to the instruction ROM; equals fetch_pc.
- rom_data  in  32  instruction word returned combinationally for rom_addr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced to 0).
- out_valid  out  1  queue head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- q_count  out  $clog2(DEPTH+1)  current occupancy, for debug.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetch_pc = RESET_PC, wr_ptr = rd_ptr = 0, count = 0.
  - Outputs: out_valid = 0, out_pc = 0, out_instr = 0, q_count = 0, rom_addr = RESET_PC.
- rom_addr = fetch_pc, driven combinationally from the register.
- pop = out_valid && out_ready.
- push = !redirect_valid && (count < DEPTH || pop).
- On push, storage[wr_ptr] <= {fetch_pc, rom_data}, wr_ptr advances, and fetch_pc <= fetch_pc + 4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- On pop, rd_ptr advances.
- Pointer rules: width $clog2(DEPTH); they wrap naturally at DEPTH.
- count update: count <= count + push - pop.
- Full with no pop: no push; fetch_pc holds and rom_addr stays stable.
- Full with pop in the same cycle: push and pop both occur; count stays at DEPTH.
- Empty: out_valid = 0 and out_pc/out_instr are forced to 0. out_ready is don't-care.
- Latency, bypass disabled: an instruction fetched in cycle N appears on out_* in cycle N+1.
- Redirect (redirect_valid = 1) has highest priority. In that cycle:
  - count <= 0, wr_ptr <= 0, rd_ptr <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push occurs.
  - A pop shown that cycle is still a legal handshake for decode, but the queue is flushed regardless.
- First entry after a redirect: pushed in cycle N+1 and visible on out_* in cycle N+2 (bypass disabled).
- Reset asserted mid-operation: all state clears immediately. No partial entries survive, and no out_valid pulse occurs during reset.
- out_* are held stable while out_valid && !out_ready (standard valid/ready hold).

Optional Feature:
- Macro: IF_FETCH_BYPASS_EN.
- Defined: when count == 0 and !redirect_valid:
  - out_valid = 1, out_pc = fetch_pc, out_instr = rom_data, all combinationally.
  - If out_ready, the entry is consumed directly: fetch_pc advances by 4 and nothing is written to the queue.
  - If !out_ready, a normal push occurs.
  - Zero-cycle fetch latency when the queue is empty.
- Not defined: registered-only output as described in Behaviour; 1-cycle latency.

Decomposition:
- Package if_pkg:
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
  - localparam NOP_INSTR = 32'h0000_0013.
  - localparam DEFAULT_RESET_PC = 32'h0.
- Sub-module if_fifo: generic DEPTH-entry FIFO of fetch_entry_t with push/pop/flush/count.
- if_fetch_queue keeps the PC register, push/redirect control and the bypass mux.

Test Plan:
- Reset with RESET_PC=0, out_ready=0 → rom_addr steps 0,4,8,12 then holds at 0x10; q_count=4; out_valid=1, out_pc=0.
- Continuous out_ready=1 with ROM returning addr-tagged words → out_pc sequence 0,4,8,… with one entry per cycle after the first; q_count stays at 1; no gaps.
- Full queue (count=4) with out_ready=1 for one cycle → push and pop together; q_count stays 4; new tail PC = 0x10; rom_addr → 0x14.
- Redirect to 0x22 while 3 entries are queued → next cycle q_count=0, out_valid=0, rom_addr=0x20; following cycle out_pc=0x20; old PCs never appear on out_*.
- Fetch from 32'hFFFF_FFFC → next rom_addr=0x0; the entry pair is {FFFF_FFFC, data} followed by {0, data}.
- Reset deasserted-then-asserted mid-stream with count=2 → out_valid=0 and q_count=0 immediately, before the next clk edge; rom_addr=RESET_PC. With IF_FETCH_BYPASS_EN, empty queue and out_ready=1 → out_valid=1 in the same cycle with out_pc=rom_addr.
